// File: rtl/cmd_phy.sv
// -----------------------------------------------------------------------------
// cmd_phy -- bit-level CMD-line engine of the SD host.
//
// Sends a 48-bit command frame (start, transmission bit, index, argument,
// CRC7, end bit) MSB first. It then turns the pad around, waits for the
// card's start bit with a timeout, and deserializes a 48-bit or 136-bit
// response. Completion, timeout and CRC status go back to the command
// controller.
//
// Build option:
//   CMD_PHY_CRC_CHECK_EN  defined   : CRC7 of 48-bit responses is checked;
//                                     crc_err is set on mismatch.
//                         undefined : receive CRC logic omitted, crc_err = 0.
//   The transmit CRC is always generated.
//
// Parameters:
//   TIMEOUT           sd_clock cycles waited for the response start bit.
//
// Ports:
//   sd_clock          card clock; all logic runs on the rising edge
//   reset             asynchronous, active-high reset
//   strobe_in         start request, sampled only in IDLE
//   cmd_index[5:0]    command index
//   cmd_arg[31:0]     command argument
//   resp_none         1: no response expected
//   resp_long         1: 136-bit (R2) response, else 48-bit
//   pad_output_input  pad direction, 1 = host drives the line
//   pad_enable        pad output enable
//   pad_data_in       serial bit to the pad
//   pad_data_out      serial bit from the pad (line value)
//   busy              high from the accepted strobe until done
//   done              one-cycle completion pulse
//   timeout_err       response start bit timed out; valid with done
//   crc_err           response CRC mismatch; valid with done
//   resp_data[127:0]  captured response payload
//
// State table:
//   state        | meaning
//   S_IDLE       | pad released, waiting for strobe_in
//   S_SEND       | driving the 48 command bits onto the line
//   S_WAIT_START | pad released, waiting for the card start bit
//   S_RECV       | shifting in the remaining response bits
//   S_DONE       | done pulse cycle, back to idle next
// -----------------------------------------------------------------------------
module cmd_phy #(
  parameter int TIMEOUT = 64
) (
  input  logic         sd_clock,
  input  logic         reset,
  input  logic         strobe_in,
  input  logic [5:0]   cmd_index,
  input  logic [31:0]  cmd_arg,
  input  logic         resp_none,
  input  logic         resp_long,
  output logic         pad_output_input,
  output logic         pad_enable,
  output logic         pad_data_in,
  input  logic         pad_data_out,
  output logic         busy,
  output logic         done,
  output logic         timeout_err,
  output logic         crc_err,
  output logic [127:0] resp_data
);

  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_WAIT_START,
    S_RECV,
    S_DONE
  } state_t;

  // Serial CRC7, polynomial x^7 + x^3 + 1, initial value 0, MSB first.
  function automatic logic [6:0] crc7_calc(input logic [39:0] data);
    logic [6:0] crc;
    logic       fb;
    crc = '0;
    for (int i = 39; i >= 0; i--) begin
      fb  = data[i] ^ crc[6];
      crc = {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    end
    return crc;
  endfunction

  state_t              state;
  logic [46:0]         tx_sr;      // bits still to send after the one on the pad
  logic [7:0]          bit_cnt;    // bits left in the current SEND/RECV phase
  logic [WAIT_W-1:0]   wait_cnt;   // start-bit timeout, counts down to 0
  logic [126:0]        rx_sr;      // response bits received so far (start bit dropped)
  logic                none_q;
  logic                long_q;

  logic [39:0]         tx_hdr;
  logic [47:0]         tx_frame;

  assign tx_hdr   = {2'b01, cmd_index, cmd_arg};
  assign tx_frame = {tx_hdr, crc7_calc(tx_hdr), 1'b1};

`ifndef CMD_PHY_CRC_CHECK_EN
  assign crc_err = 1'b0;
`endif

  always_ff @(posedge sd_clock or posedge reset) begin
    if (reset) begin
      state            <= S_IDLE;
      pad_output_input <= 1'b0;
      pad_enable       <= 1'b0;
      pad_data_in      <= 1'b1;
      busy             <= 1'b0;
      done             <= 1'b0;
      timeout_err      <= 1'b0;
`ifdef CMD_PHY_CRC_CHECK_EN
      crc_err          <= 1'b0;
`endif
      resp_data        <= '0;
      tx_sr            <= '0;
      bit_cnt          <= '0;
      wait_cnt         <= '0;
      rx_sr            <= '0;
      none_q           <= 1'b0;
      long_q           <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (strobe_in) begin
            none_q           <= resp_none;
            long_q           <= resp_long;
            timeout_err      <= 1'b0;
`ifdef CMD_PHY_CRC_CHECK_EN
            crc_err          <= 1'b0;
`endif
            resp_data        <= '0;
            // Start bit goes out in the first SEND cycle; the rest is queued.
            pad_output_input <= 1'b1;
            pad_enable       <= 1'b1;
            pad_data_in      <= tx_frame[47];
            tx_sr            <= tx_frame[46:0];
            bit_cnt          <= 8'd47;
            busy             <= 1'b1;
            state            <= S_SEND;
          end
        end

        S_SEND: begin
          if (bit_cnt == 8'd0) begin
            // End bit has been on the line this cycle: turn the pad around.
            pad_output_input <= 1'b0;
            pad_enable       <= 1'b0;
            pad_data_in      <= 1'b1;
            if (none_q) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              wait_cnt <= WAIT_W'(TIMEOUT - 1);
              state    <= S_WAIT_START;
            end
          end else begin
            pad_data_in <= tx_sr[46];
            tx_sr       <= {tx_sr[45:0], 1'b0};
            bit_cnt     <= bit_cnt - 1'b1;
          end
        end

        S_WAIT_START: begin
          if (!pad_data_out) begin
            rx_sr   <= '0;
            bit_cnt <= long_q ? 8'd134 : 8'd46;
            state   <= S_RECV;
          end else if (wait_cnt == '0) begin
            timeout_err <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b1;
            state       <= S_DONE;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end

        S_RECV: begin
          rx_sr <= {rx_sr[125:0], pad_data_out};
          if (bit_cnt == 8'd0) begin
            // The bit arriving now is the end bit; rx_sr already holds
            // frame bits 127..1 (long) or 46..1 (short).
            if (long_q) begin
              resp_data <= {rx_sr, 1'b0};
            end else begin
              resp_data <= {90'd0, rx_sr[44:7]};
            end
`ifdef CMD_PHY_CRC_CHECK_EN
            crc_err <= !long_q &&
                       (crc7_calc({1'b0, rx_sr[45:7]}) != rx_sr[6:0]);
`endif
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            bit_cnt <= bit_cnt - 1'b1;
          end
        end

        S_DONE: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/cmd_phy.md
# cmd_phy

- Bit-level CMD-line engine of the SD host; sits directly upstream of the CMD pad.
- Transmits a 48-bit command frame with generated CRC7, then turns the pad around to input.
- Waits for the card's start bit with a timeout and deserializes a 48-bit or 136-bit response.
- Reports completion, timeout and CRC status to the command controller.

## Interface

Parameters:
- TIMEOUT, 64: maximum sd_clock cycles waited for the response start bit (N_CR limit).

Ports (one clock, `sd_clock`; reset is asynchronous and active-high):
- sd_clock  input  1  card clock; all logic on rising edge
- reset  input  1  asynchronous, active-high reset
- strobe_in  input  1  start request; sampled only in IDLE
- cmd_index  input  6  command index
- cmd_arg  input  32  command argument
- resp_none  input  1  1: no response expected
- resp_long  input  1  1: 136-bit response (R2), else 48-bit
- pad_output_input  output  1  pad direction, 1 = host drives line
- pad_enable  output  1  pad output enable
- pad_data_in  output  1  serial bit to pad
- pad_data_out  input  1  serial bit from pad (line value)
- busy  output  1  high from accepted strobe until done
- done  output  1  one-cycle completion pulse
- timeout_err  output  1  valid with done
- crc_err  output  1  valid with done
- resp_data  output  128  captured response payload

## Operation

- States: IDLE, SEND, WAIT_START, RECV, DONE.
- IDLE:
  - On strobe_in=1, latch cmd_index, cmd_arg, resp_none and resp_long.
  - Clear the error flags and go to SEND.
  - strobe_in in any other state is ignored.
- SEND:
  - Shift 48 bits MSB first: start 0, transmission 1, index[5:0], arg[31:0], CRC7[6:0], end 1.
  - CRC7 polynomial x^7+x^3+1, initial 0, computed over bits 47..8.
  - pad_output_input=1 and pad_enable=1 throughout.
  - After the end bit: if resp_none, go to DONE; else go to WAIT_START.
- WAIT_START:
  - Pad released (pad_output_input=0, pad_enable=0); counter increments each cycle.
  - pad_data_out=0 goes to RECV.
  - If the counter reaches TIMEOUT without a start bit, set timeout_err and go to DONE.
- RECV:
  - Shift 47 remaining bits (48-bit response) or 135 (long response).
  - 48-bit response: resp_data[37:0] = frame bits 45:8 (transmission bit excluded, index + argument), upper bits 0.
  - 48-bit response: CRC7 is computed over frame bits 47..8 and compared with bits 7:1.
  - Long response: resp_data[127:1] = frame bits 127:1, resp_data[0]=0; no CRC check (payload carries its own).
  - Go to DONE after the end bit; the end bit value is not checked.
- DONE: done=1 for one cycle, busy=0 in the same cycle, return to IDLE.
- Reset values:
  - State IDLE, pad_output_input=0, pad_enable=0, pad_data_in=1.
  - busy=0, done=0, timeout_err=0, crc_err=0, resp_data=0.
- Reset mid-operation: outputs return to reset values immediately (asynchronously) and the transfer is abandoned; no done pulse.
- resp_data holds its value until the next accepted strobe, which clears it.

## Timing

- Cycle 0: strobe_in sampled; busy=1 from cycle 1.
- Start bit on pad_data_in in cycle 1; end bit in cycle 48.
- Cycle 49: pad released (WAIT_START). With resp_none, done=1 instead.
- Start bit sampled in the first cycle the line reads 0; counter starts at 1 in cycle 49.
- Timeout: done in the cycle after the TIMEOUT-th sampled high bit.
- 48-bit response: done one cycle after the 48th response bit is sampled. Long response: one cycle after the 136th.
- No back-to-back commands: next strobe is accepted no earlier than the cycle after done.

## Configuration

- Macro `CMD_PHY_CRC_CHECK_EN`.
- Defined: receive CRC7 check built as specified; crc_err is set on mismatch.
- Undefined: receive CRC logic omitted; crc_err is constant 0. Transmit CRC is always generated.

## Test plan

- CMD0, arg 0x00000000, resp_none=1 -> pad_data_in serial 0x400000000095 over cycles 1–48; done in cycle 49; no errors.
- CMD8, arg 0x000001AA, 48-bit response -> transmits 0x48000001AA87.
  - Bench drives 0x08000001AA13 after 5 idle cycles.
  - Required: resp_data[37:0]=0x08000001AA (bits 37:32 = index 0x08, bits 31:0 = 0x000001AA); crc_err=0; timeout_err=0.
- Same as above but response CRC byte 0x15 -> crc_err=1 (only when `CMD_PHY_CRC_CHECK_EN` is defined); done still pulses.
- Line held high after CMD8 -> timeout_err=1 and done after 64 wait cycles; resp_data=0.
- Long response with bits 127:1 = 0x5A repeated -> resp_data matches, LSB 0; crc_err=0.
- Strobe pulsed during SEND is ignored. Reset asserted at cycle 20 of SEND -> all outputs at reset values, no done; a new strobe is then accepted normally.
